// File: rtl/program_loader.sv
// Boot-image loader: takes a [length][data...][checksum] byte stream, builds a
// 256-byte program image and releases the downstream CPU once the checksum matches.
module program_loader #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic [2047:0] code,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [8:0]    byte_count,
  output logic [2:0]    o_state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_SUM  = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [2047:0]   r_code;
  logic [8:0]      r_count;
  logic [8:0]      r_len;
  logic [7:0]      r_sum;
  logic [15:0]     r_tmo;

  logic            w_loading;
  logic            w_xfer;
  logic            w_timeout;
  logic            w_start_ok;
  logic            w_last_data;
  logic            w_sum_ok;
  logic            w_enter_err;

  // Handshake: a byte moves only when in_valid and in_ready are both high in the
  // same cycle; in_ready depends on state alone, so the source may hold in_valid
  // high indefinitely and in_data is ignored whenever no transfer happens.
  assign w_loading   = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_SUM);
  assign w_xfer      = in_valid && in_ready;
  assign w_timeout   = w_loading && !w_xfer &&
                       (({1'b0, r_tmo} + 17'd1) >= {1'b0, TIMEOUT});
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_RUN) ||
                                 (r_state == S_ERR));
  assign w_last_data = ((r_count + 9'd1) == r_len);
  assign w_sum_ok    = (in_data == r_sum);
  assign w_enter_err = (r_state != S_ERR) && (w_state_next == S_ERR);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_RUN, S_ERR: begin
        if (w_start_ok) begin
          w_state_next = S_LEN;
        end
      end
      S_LEN: begin
        if (w_xfer) begin
          w_state_next = S_DATA;
        end else if (w_timeout) begin
          w_state_next = S_ERR;
        end
      end
      S_DATA: begin
        if (w_xfer) begin
          if (w_last_data) begin
            w_state_next = S_SUM;
          end
        end else if (w_timeout) begin
          w_state_next = S_ERR;
        end
      end
      S_SUM: begin
        if (w_xfer) begin
          w_state_next = w_sum_ok ? S_RUN : S_ERR;
        end else if (w_timeout) begin
          w_state_next = S_ERR;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode: every status flag is a pure function of the current state
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    case (r_state)
      S_LEN, S_DATA, S_SUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_RUN: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
      end
      S_ERR: begin
        error = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Load datapath: image, byte counter, running sum, length and idle timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_code  <= '0;
      r_count <= '0;
      r_len   <= '0;
      r_sum   <= '0;
      r_tmo   <= '0;
    end else begin
      if (w_start_ok) begin
        r_code  <= '0;
        r_count <= '0;
        r_sum   <= '0;
        r_tmo   <= '0;
      end else if (w_loading) begin
        if (w_xfer) begin
          r_tmo <= '0;
        end else if (r_tmo != 16'hFFFF) begin
          r_tmo <= r_tmo + 16'd1;
        end
      end

      if ((r_state == S_LEN) && w_xfer) begin
        r_len <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
      end

      if ((r_state == S_DATA) && w_xfer) begin
        r_code[{r_count[7:0], 3'b000} +: 8] <= in_data;
        r_sum <= r_sum + in_data;
        if (r_count != 9'd256) begin
          r_count <= r_count + 9'd1;
        end
      end

      // A failed or stalled load must never leave a partial image visible
      if (w_enter_err) begin
        r_code <= '0;
      end
    end
  end

  assign code        = r_code;
  assign byte_count  = r_count;
  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a byte-array load model is stepped every
// clock and compared against the DUT each cycle, plus literal spot checks.
module tb_program_loader;

  localparam logic [15:0] TMO = 16'd5;

  localparam int P_WAIT = 0;
  localparam int P_HDR  = 1;
  localparam int P_BODY = 2;
  localparam int P_CHK  = 3;
  localparam int P_GO   = 4;
  localparam int P_BAD  = 5;

  logic          clk;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [2047:0] code;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [8:0]    byte_count;
  logic [2:0]    state_dbg;

  int n_checks;
  int n_errors;
  bit chk_on;

  logic [7:0] m_img [256];
  int m_ph, m_cnt, m_len, m_sum, m_idle;

  logic [7:0] stim_q[$];
  logic [7:0] exp_q[$];

  program_loader #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .code       (code),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .byte_count (byte_count),
    .o_state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_code(input string name, input logic [2047:0] act,
                            input logic [2047:0] exp);
    int first;
    first = -1;
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      for (int k = 255; k >= 0; k--) begin
        if (act[8*k +: 8] !== exp[8*k +: 8]) first = k;
      end
      $display("FAIL %s: code byte %0d got %h expected %h at %0t", name, first,
               act[8*first +: 8], exp[8*first +: 8], $time);
    end
  endtask

  // Behavioural model of a load
  task automatic model_clear_img();
    for (int k = 0; k < 256; k++) m_img[k] = 8'h00;
  endtask

  task automatic model_reset();
    model_clear_img();
    m_ph = P_WAIT;
    m_cnt = 0;
    m_len = 0;
    m_sum = 0;
    m_idle = 0;
  endtask

  task automatic model_step();
    bit loading;
    loading = (m_ph == P_HDR) || (m_ph == P_BODY) || (m_ph == P_CHK);
    if (!loading) begin
      if (start) begin
        model_clear_img();
        m_cnt = 0;
        m_sum = 0;
        m_idle = 0;
        m_ph = P_HDR;
      end
      return;
    end
    if (!in_valid) begin
      m_idle++;
      if (m_idle >= int'(TMO)) begin
        m_ph = P_BAD;
        model_clear_img();
      end
      return;
    end
    m_idle = 0;
    case (m_ph)
      P_HDR: begin
        m_len = (in_data == 8'h00) ? 256 : int'(in_data);
        m_ph = P_BODY;
      end
      P_BODY: begin
        m_img[m_cnt % 256] = in_data;
        if (m_cnt < 256) m_cnt++;
        m_sum = (m_sum + int'(in_data)) % 256;
        if (m_cnt == m_len) m_ph = P_CHK;
      end
      default: begin
        if (int'(in_data) == m_sum) begin
          m_ph = P_GO;
        end else begin
          m_ph = P_BAD;
          model_clear_img();
        end
      end
    endcase
  endtask

  function automatic logic [2047:0] model_code();
    logic [2047:0] c;
    for (int k = 0; k < 256; k++) c[8*k +: 8] = m_img[k];
    return c;
  endfunction

  always begin
    @(posedge clk or posedge reset);
    if (reset) model_reset();
    else model_step();
  end

  // Per-cycle compare against the model
  always begin
    bit ld;
    @(negedge clk);
    if (chk_on) begin
      ld = (m_ph == P_HDR) || (m_ph == P_BODY) || (m_ph == P_CHK);
      check("cyc_in_ready", 32'(in_ready), 32'(ld));
      check("cyc_busy", 32'(busy), 32'(ld));
      check("cyc_done", 32'(done), 32'(m_ph == P_GO));
      check("cyc_error", 32'(error), 32'(m_ph == P_BAD));
      check("cyc_cpu_reset", 32'(cpu_reset), 32'(m_ph != P_GO));
      check("cyc_byte_count", 32'(byte_count), 32'(m_cnt));
      check_code("cyc_code", code, model_code());
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data = 8'($urandom);
      start = poke && (g == 0);
      tick();
      start = 1'b0;
    end
    in_valid = 1'b1;
    in_data = b;
    tick();
    in_valid = 1'b0;
    in_data = 8'($urandom);
  endtask

  task automatic send_stream(input int max_gap, input bit pokes);
    int gap;
    bit poke;
    for (int i = 0; i < stim_q.size(); i++) begin
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      poke = 1'b0;
      if (pokes) begin
        if (i == 2 && gap == 0) gap = 1;
        poke = (i == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      send_byte(stim_q[i], gap, poke);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_byte_count"}, 32'(byte_count), 32'd0);
    check_code({tag, "_code"}, code, '0);
  endtask

  logic [2047:0] e;

  initial begin
    n_checks = 0;
    n_errors = 0;
    chk_on = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    reset = 1'b1;
    #2;
    check_reset_values("por");
    chk_on = 1'b1;
    #10 reset = 1'b0;
    tick();
    repeat (3) tick();
    check("idle_wait_busy", 32'(busy), 32'd0);

    // Basic 3-byte load
    do_start();
    check("t1_start_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t1_start_busy", 32'(busy), 32'd1);
    stim_q = '{8'h03, 8'hAA, 8'h01, 8'h02, 8'hAD};
    send_stream(0, 1'b0);
    e = '0;
    e[23:0] = 24'h0201AA;
    check_code("t1_code", code, e);
    check("t1_done", 32'(done), 32'd1);
    check("t1_cpu_reset", 32'(cpu_reset), 32'd0);
    check("t1_byte_count", 32'(byte_count), 32'd3);
    check("t1_model_sum", 32'(m_sum), 32'hAD);
    repeat (3) tick();

    // Bad checksum, then a good reload; start from RUN halts the CPU
    do_start();
    check("t2_rerun_cpu_reset", 32'(cpu_reset), 32'd1);
    stim_q = '{8'h02, 8'h10, 8'h20, 8'h31};
    send_stream(0, 1'b0);
    check("t2_error", 32'(error), 32'd1);
    check("t2_cpu_reset", 32'(cpu_reset), 32'd1);
    check_code("t2_code", code, '0);
    repeat (2) tick();
    check("t2_error_hold", 32'(error), 32'd1);
    do_start();
    check("t2_error_clear", 32'(error), 32'd0);
    stim_q = '{8'h02, 8'h10, 8'h20, 8'h30};
    send_stream(0, 1'b0);
    check("t2_reload_done", 32'(done), 32'd1);
    check("t2_reload_lo", 32'(code[15:0]), 32'h2010);

    // Full 256-byte image
    do_start();
    stim_q = '{8'h00};
    for (int k = 0; k < 256; k++) stim_q.push_back(8'(k));
    stim_q.push_back(8'h80);
    send_stream(0, 1'b0);
    check("t3_done", 32'(done), 32'd1);
    check("t3_byte_count", 32'(byte_count), 32'd256);
    check("t3_top_byte", 32'(code[2047:2040]), 32'hFF);
    check("t3_mid_byte", 32'(code[1023:1016]), 32'h7F);
    check("t3_model_len", 32'(m_len), 32'd256);

    // Timeout fires on the 5th idle cycle
    do_start();
    send_byte(8'h01, 0, 1'b0);
    repeat (4) tick();
    check("t4_alive_error", 32'(error), 32'd0);
    check("t4_alive_busy", 32'(busy), 32'd1);
    tick();
    check("t4_timeout_error", 32'(error), 32'd1);
    check("t4_timeout_busy", 32'(busy), 32'd0);
    // A transfer on that same cycle keeps the load going
    do_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h77, 4, 1'b0);
    check("t4_keep_error", 32'(error), 32'd0);
    check("t4_keep_busy", 32'(busy), 32'd1);
    check("t4_keep_count", 32'(byte_count), 32'd1);
    send_byte(8'h77, 0, 1'b0);
    check("t4_keep_done", 32'(done), 32'd1);
    check("t4_keep_code", 32'(code[7:0]), 32'h77);

    // Asynchronous reset mid-DATA
    do_start();
    send_byte(8'h04, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    check("t5_pre_count", 32'(byte_count), 32'd2);
    #2 reset = 1'b1;
    #1;
    check_reset_values("t5_async");
    @(negedge clk);
    reset = 1'b0;
    tick();
    do_start();
    stim_q = '{8'h02, 8'h5A, 8'hA5, 8'hFF};
    send_stream(0, 1'b0);
    check("t5_reload_done", 32'(done), 32'd1);
    check("t5_reload_lo", 32'(code[15:0]), 32'hA55A);

    // Same payload with and without random gaps and stray start pulses
    for (int pass = 0; pass < 2; pass++) begin
      do_start();
      stim_q = '{8'h06, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'h04};
      exp_q = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
      send_stream((pass == 0) ? 0 : 3, pass == 1);
      check("t6_done", 32'(done), 32'd1);
      check("t6_byte_count", 32'(byte_count), 32'd6);
      e = '0;
      for (int k = 0; exp_q.size() > 0; k++) e[8*k +: 8] = exp_q.pop_front();
      check_code("t6_image", code, e);
    end

    repeat (2) tick();
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd1000: the maximum idle cycles between accepted bytes while loading.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: a level-sampled request to begin a new load.
REQ-005 SHALL have port in_valid, input, 1 bit: the source has a byte on in_data.
REQ-006 SHALL have port in_data, input, 8 bits: the load stream byte.
REQ-007 SHALL have port in_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-008 SHALL have port code, output, 2048 bits: the program image, with byte k at bits [8k+7:8k]; it feeds the CPU code input.
REQ-009 SHALL have port cpu_reset, output, 1 bit: the reset for the downstream CPU.
REQ-010 SHALL have port busy, output, 1 bit: high in states LEN, DATA and SUM.
REQ-011 SHALL have port done, output, 1 bit: high in state RUN.
REQ-012 SHALL have port error, output, 1 bit: high in state ERR.
REQ-013 SHALL have port byte_count, output, 9 bits: the number of data bytes written in the current load.

Function
REQ-014 SHALL implement a state machine with states IDLE, LEN, DATA, SUM, RUN and ERR; all outputs SHALL be registered or decoded from state.
REQ-015 SHALL count a transfer only in a cycle where in_valid and in_ready are both 1; in_data SHALL be ignored otherwise.
REQ-016 SHALL drive in_ready = 1 only in LEN, DATA and SUM.
REQ-017 SHALL, when start = 1 in IDLE, RUN or ERR: go to LEN next cycle, zero all 256 image bytes, zero byte_count, zero the running sum, set cpu_reset = 1 and reload the timeout counter.
REQ-018 SHALL ignore start while in LEN, DATA or SUM.
REQ-019 LEN SHALL, on a transfer, latch length N = in_data (0 means 256) and go to DATA.
REQ-020 DATA SHALL, on each transfer, write in_data to image byte byte_count[7:0], increment byte_count, and add in_data to an 8-bit sum (mod 256).
REQ-021 DATA SHALL go to SUM on the transfer that makes byte_count equal N.
REQ-022 SUM SHALL, on a transfer, compare in_data with the sum: equal goes to RUN, unequal goes to ERR.
REQ-023 The length byte and checksum byte SHALL NOT be included in the sum.
REQ-024 RUN SHALL drive cpu_reset = 0 and done = 1, starting the first cycle after the accepted checksum byte; the image SHALL then be held constant.
REQ-025 Entering ERR SHALL zero the image, set cpu_reset = 1 and set error = 1; error SHALL hold until start or reset.
REQ-026 Timeout: in LEN, DATA or SUM, a counter SHALL count cycles without a transfer and reload on every transfer.
REQ-027 On the cycle the timeout counter reaches TIMEOUT, the block SHALL go to ERR.
REQ-028 If a transfer occurs in the same cycle the counter reaches TIMEOUT, the transfer SHALL take priority.
REQ-029 byte_count SHALL saturate at 256; the write address wraps only through N = 0 (256 bytes filling addresses 0..255).
REQ-030 Image bytes at addresses ≥ N SHALL remain 0.
REQ-031 A start asserted in RUN SHALL re-assert cpu_reset on the next cycle (the CPU is halted for reload).

Reset
REQ-032 Asserting reset SHALL immediately, without waiting for clk, force: state IDLE, code = 0, cpu_reset = 1, in_ready = 0, busy = 0, done = 0, error = 0, byte_count = 0, sum = 0, timeout counter = 0.
REQ-033 Reset asserted mid-load SHALL abandon the load with no partial image retained.
REQ-034 After reset deassertion, the block SHALL wait in IDLE for start.

Verification
REQ-035 Bench SHALL cover: start, stream 03, AA, 01, 02, AD → code[23:0] = 24'h0201AA, other bits 0, done = 1, cpu_reset = 0, byte_count = 3.
REQ-036 Bench SHALL cover: start, stream 02, 10, 20, 31 (bad checksum) → error = 1, code = 0, cpu_reset = 1; then a valid reload reaches RUN.
REQ-037 Bench SHALL cover: length byte 00 followed by 256 bytes of value k at address k and checksum 80 → RUN, code[2047:2040] = FF, byte_count = 256.
REQ-038 Bench SHALL cover: with TIMEOUT = 5, start, send 01, then hold in_valid = 0 for 5 cycles → ERR exactly on the 5th idle cycle; a transfer on that cycle instead keeps the load alive.
REQ-039 Bench SHALL cover: asynchronous reset pulse between clock edges mid-DATA → outputs hit reset values before the next edge; a later start loads cleanly.
REQ-040 Bench SHALL cover: random in_valid gaps below TIMEOUT → image is identical to the gap-free run and start is ignored while busy.
